lockstep_dly_cmp_buf: RTL and testbench



---
 rtl/lockstep_dly_cmp_buf.sv | 117 +++++++++++
 tb/tb_lockstep_dly_cmp_buf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_dly_cmp_buf.sv
// Lockstep delay-and-compare buffer: delays the main-core bundle DEPTH cycles and checks it against the shadow core.
// Optional macro LOCKSTEP_BUF_MASK_EN adds a per-bit cmp_mask input that excludes bits from the data compare.
module lockstep_dly_cmp_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  input  logic             chk_vld,
  input  logic [WIDTH-1:0] chk_data,
`ifdef LOCKSTEP_BUF_MASK_EN
  input  logic [WIDTH-1:0] cmp_mask,
`endif
  input  logic             err_clr,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             primed,
  output logic [CNTW-1:0]  fill_cnt,
  output logic             mismatch,
  output logic             err_sticky
);

  generate
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("lockstep_dly_cmp_buf: DEPTH must be in 1..8");
    end
    if ((2 ** CNTW) <= DEPTH) begin : g_bad_cntw
      $error("lockstep_dly_cmp_buf: CNTW too narrow for DEPTH");
    end
  endgenerate

  logic [DEPTH-1:0]            stg_vld_q, stg_vld_d, shift_vld;
  logic [DEPTH-1:0][WIDTH-1:0] stg_data_q, stg_data_d, shift_data;
  logic [CNTW-1:0]             fill_cnt_q, fill_cnt_d;
  logic                        mismatch_q, mismatch_d;
  logic                        err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0]            data_diff;
  logic                        raw_mis;

  // Stage 0 takes the live inputs; every later stage takes its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign shift_vld[gi]  = in_vld;
        assign shift_data[gi] = in_data;
      end else begin : g_body
        assign shift_vld[gi]  = stg_vld_q[gi-1];
        assign shift_data[gi] = stg_data_q[gi-1];
      end
    end
  endgenerate

  assign out_vld    = stg_vld_q[DEPTH-1];
  assign out_data   = stg_data_q[DEPTH-1];
  assign fill_cnt   = fill_cnt_q;
  assign primed     = (fill_cnt_q == CNTW'(DEPTH));
  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;

`ifdef LOCKSTEP_BUF_MASK_EN
  assign data_diff = (out_data ^ chk_data) & ~cmp_mask;
`else
  assign data_diff = out_data ^ chk_data;
`endif

  // Data only matters when both sides claim a valid bundle.
  assign raw_mis = primed &
                   ((out_vld != chk_vld) | (out_vld & chk_vld & (|data_diff)));

  always_comb begin
    stg_vld_d    = shift_vld;
    stg_data_d   = shift_data;
    fill_cnt_d   = fill_cnt_q;
    mismatch_d   = raw_mis;
    err_sticky_d = err_sticky_q;

    if (fill_cnt_q != CNTW'(DEPTH)) begin
      fill_cnt_d = fill_cnt_q + CNTW'(1);
    end

    if (flush) begin
      stg_vld_d  = '0;
      stg_data_d = '0;
      fill_cnt_d = '0;
      mismatch_d = 1'b0;
    end

    // A new error outranks a clear request in the same cycle.
    if (raw_mis) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld_q    <= '0;
      stg_data_q   <= '0;
      fill_cnt_q   <= '0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      stg_vld_q    <= stg_vld_d;
      stg_data_q   <= stg_data_d;
      fill_cnt_q   <= fill_cnt_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule

// File: tb/tb_lockstep_dly_cmp_buf.sv
// Directed bench for lockstep_dly_cmp_buf (WIDTH=32, DEPTH=2); LOCKSTEP_BUF_MASK_EN enables the mask vectors.
module tb_lockstep_dly_cmp_buf;
  localparam int W  = 32;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_vld, chk_vld, err_clr;
  logic [W-1:0]  in_data, chk_data;
  logic          out_vld, primed, mismatch, err_sticky;
  logic [W-1:0]  out_data;
  logic [CW-1:0] fill_cnt;
`ifdef LOCKSTEP_BUF_MASK_EN
  logic [W-1:0]  cmp_mask;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int cyc_no = 0;

  // History of bundles driven since the last reset/flush (expected delay-line contents).
  logic          hv[$];
  logic [W-1:0]  hd[$];

  always #5 clk = ~clk;

  lockstep_dly_cmp_buf #(.WIDTH(W), .DEPTH(D), .CNTW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_vld     (in_vld),
    .in_data    (in_data),
    .chk_vld    (chk_vld),
    .chk_data   (chk_data),
`ifdef LOCKSTEP_BUF_MASK_EN
    .cmp_mask   (cmp_mask),
`endif
    .err_clr    (err_clr),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .primed     (primed),
    .fill_cnt   (fill_cnt),
    .mismatch   (mismatch),
    .err_sticky (err_sticky)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, clock it, and sample 1 time unit after the edge.
  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic cv,
                     input logic [W-1:0] cd, input logic clr, input logic fl);
    in_vld = iv; in_data = id; chk_vld = cv; chk_data = cd; err_clr = clr; flush = fl;
    @(posedge clk);
    #1;
    if (fl || rst) begin
      hv.delete(); hd.delete();
    end else begin
      hv.push_back(iv); hd.push_back(id);
    end
    cyc_no++;
    $display("cyc %0d rst=%b fl=%b clr=%b in=%b/%h chk=%b/%h -> out=%b/%h fill=%0d primed=%b mis=%b err=%b",
             cyc_no, rst, fl, clr, iv, id, cv, cd, out_vld, out_data, fill_cnt, primed, mismatch, err_sticky);
  endtask

  // Cycle whose shadow input equals the bundle currently leaving the delay line.
  task automatic mcyc(input logic iv, input logic [W-1:0] id, input logic clr);
    logic          cv;
    logic [W-1:0]  cd;
    cv = (hv.size() >= 2) ? hv[hv.size()-2] : 1'b0;
    cd = (hd.size() >= 2) ? hd[hd.size()-2] : '0;
    cyc(iv, id, cv, cd, clr, 1'b0);
  endtask

  task automatic check_out(input string tag);
    check_val({tag, "_vld"},  32'(out_vld),  32'(hv[hv.size()-2]));
    check_val({tag, "_data"}, out_data,      hd[hd.size()-2]);
  endtask

  initial begin
    logic [W-1:0] cur;
    rst = 1'b1; flush = 1'b0; err_clr = 1'b0;
    in_vld = 1'b0; in_data = '0; chk_vld = 1'b0; chk_data = '0;
`ifdef LOCKSTEP_BUF_MASK_EN
    cmp_mask = '0;
`endif
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h1, 1'b0, 1'b0);
    check_val("rst_out_vld", 32'(out_vld), 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_fill", 32'(fill_cnt), 0);
    check_val("rst_primed", 32'(primed), 0);
    check_val("rst_mismatch", 32'(mismatch), 0);
    check_val("rst_err", 32'(err_sticky), 0);

    // Fill: 0x11, 0x22, 0x33
    rst = 1'b0;
    cyc(1'b1, 32'h11, 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("fill1_cnt", 32'(fill_cnt), 1);
    check_val("fill1_primed", 32'(primed), 0);
    check_val("fill1_out_vld", 32'(out_vld), 0);
    cyc(1'b1, 32'h22, 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("fill2_out_data", out_data, 32'h11);
    check_val("fill2_out_vld", 32'(out_vld), 1);
    check_val("fill2_primed", 32'(primed), 1);
    check_val("fill2_cnt", 32'(fill_cnt), 2);
    check_val("fill2_mismatch", 32'(mismatch), 0);
    mcyc(1'b1, 32'h33, 1'b0);
    check_val("fill3_out_data", out_data, 32'h22);
    check_val("fill3_cnt_sat", 32'(fill_cnt), 2);
    check_val("fill3_mismatch", 32'(mismatch), 0);

    // Data error: shadow says 0x23 while 0x22 is leaving
    cyc(1'b1, 32'h44, 1'b1, 32'h23, 1'b0, 1'b0);
    check_val("derr_out_data", out_data, 32'h33);
    check_val("derr_mismatch", 32'(mismatch), 1);
    check_val("derr_err", 32'(err_sticky), 1);
    mcyc(1'b1, 32'h55, 1'b0);
    check_val("derr_pulse_end", 32'(mismatch), 0);
    check_val("derr_err_hold", 32'(err_sticky), 1);
    mcyc(1'b1, 32'h66, 1'b1);
    check_val("clr_err", 32'(err_sticky), 0);
    check_val("clr_mismatch", 32'(mismatch), 0);

    // Matching stream with valid gaps
    for (int i = 0; i < 20; i++) begin
      mcyc((i % 3) != 0, 32'h1000 + i, 1'b0);
      check_out("stream_out");
      check_val("stream_mismatch", 32'(mismatch), 0);
      check_val("stream_err", 32'(err_sticky), 0);
    end

    // Valid error: out_vld=1, chk_vld=0
    mcyc(1'b1, 32'hA0, 1'b0);
    check_val("verr_pre_mismatch", 32'(mismatch), 0);
    cyc(1'b1, 32'hA1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_val("verr_mismatch", 32'(mismatch), 1);
    check_val("verr_err", 32'(err_sticky), 1);
    // Both valids low with different data: no mismatch
    mcyc(1'b0, 32'hB0, 1'b0);
    mcyc(1'b0, 32'hB1, 1'b0);
    check_val("idle_out_vld", 32'(out_vld), 0);
    cyc(1'b0, 32'hC0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_val("idle_mismatch", 32'(mismatch), 0);

    // Flush with err_sticky set and garbage shadow input
    cyc(1'b1, 32'hE0, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
    check_val("flush_primed", 32'(primed), 0);
    check_val("flush_fill", 32'(fill_cnt), 0);
    check_val("flush_out_vld", 32'(out_vld), 0);
    check_val("flush_out_data", out_data, 0);
    check_val("flush_mismatch", 32'(mismatch), 0);
    check_val("flush_err", 32'(err_sticky), 1);
    cyc(1'b1, 32'hE1, 1'b1, 32'hBAD0, 1'b0, 1'b0);
    check_val("pflush1_mismatch", 32'(mismatch), 0);
    check_val("pflush1_fill", 32'(fill_cnt), 1);
    cyc(1'b1, 32'hE2, 1'b1, 32'hBAD1, 1'b0, 1'b0);
    check_val("pflush2_mismatch", 32'(mismatch), 0);
    check_val("pflush2_primed", 32'(primed), 1);
    check_val("pflush2_out_data", out_data, 32'hE1);
    mcyc(1'b1, 32'hE3, 1'b0);
    check_val("pflush3_mismatch", 32'(mismatch), 0);
    check_val("pflush3_err", 32'(err_sticky), 1);

    // Clear, then clear colliding with a new error
    mcyc(1'b1, 32'hE4, 1'b1);
    check_val("clr2_err", 32'(err_sticky), 0);
    cyc(1'b1, 32'hE5, 1'b0, 32'h0, 1'b1, 1'b0);
    check_val("clrset_mismatch", 32'(mismatch), 1);
    check_val("clrset_err", 32'(err_sticky), 1);
    mcyc(1'b1, 32'hE6, 1'b0);
    check_val("clrset_pulse_end", 32'(mismatch), 0);

    // Reset outranks flush and err_clr
    rst = 1'b1;
    cyc(1'b1, 32'hF0, 1'b1, 32'h0, 1'b1, 1'b1);
    check_val("rstpri_err", 32'(err_sticky), 0);
    check_val("rstpri_fill", 32'(fill_cnt), 0);
    check_val("rstpri_out_vld", 32'(out_vld), 0);
    rst = 1'b0;

`ifdef LOCKSTEP_BUF_MASK_EN
    mcyc(1'b1, 32'h0000_1230, 1'b0);
    mcyc(1'b1, 32'h0000_4560, 1'b0);
    cmp_mask = 32'h0000_00FF;
    cur = hd[hd.size()-2];
    cyc(1'b1, 32'h0000_7890, 1'b1, cur ^ 32'h0000_00AA, 1'b0, 1'b0);
    check_val("mask_low_mismatch", 32'(mismatch), 0);
    cur = hd[hd.size()-2];
    cyc(1'b1, 32'h0000_ABC0, 1'b1, cur ^ 32'h0000_0100, 1'b0, 1'b0);
    check_val("mask_high_mismatch", 32'(mismatch), 1);
`else
    cur = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
